// File: rtl/dsp_mac_ctrl_if.sv
// Signal bundle between the MAC sequencer and its surroundings: sample stream,
// coefficient port, DSP slice pins and the result handshake.
interface dsp_mac_ctrl_if #(
    parameter int AW = 2
);
    logic          S_VALID;
    logic          S_READY;
    logic [17:0]   S_DATA;
    logic          CW_EN;
    logic [AW-1:0] CW_ADDR;
    logic [17:0]   CW_DATA;
    logic [17:0]   DSP_A;
    logic [17:0]   DSP_B;
    logic [7:0]    DSP_OPMODE;
    logic          DSP_RST;
    logic [47:0]   DSP_P;
    logic          DSP_CARRYOUT;
    logic          R_VALID;
    logic          R_READY;
    logic [47:0]   R_DATA;
    logic          R_OVF;
    logic          BUSY;

    modport master (
        input  S_VALID, S_DATA, CW_EN, CW_ADDR, CW_DATA, DSP_P, DSP_CARRYOUT, R_READY,
        output S_READY, DSP_A, DSP_B, DSP_OPMODE, DSP_RST, R_VALID, R_DATA, R_OVF, BUSY
    );

    modport slave (
        output S_VALID, S_DATA, CW_EN, CW_ADDR, CW_DATA, DSP_P, DSP_CARRYOUT, R_READY,
        input  S_READY, DSP_A, DSP_B, DSP_OPMODE, DSP_RST, R_VALID, R_DATA, R_OVF, BUSY
    );
endinterface

// File: rtl/dsp_mac_ctrl.sv
// Sequencer for one DSP slice as an unsigned 18x18 MAC: issues NTAPS coefficient*sample
// products per frame and captures the accumulated P three cycles after the last tap.
module dsp_mac_ctrl #(
    parameter int NTAPS = 4,
    parameter int AW    = 2
) (
    input logic            CLK,
    input logic            RSTN,
    dsp_mac_ctrl_if.master bus
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    localparam int unsigned   NT       = NTAPS;
    localparam int            LAST     = NTAPS - 1;
    localparam logic [AW-1:0] LAST_TAP = LAST[AW-1:0];
    localparam logic [AW:0]   NTAPS_W  = NTAPS[AW:0];

    state_t        state, state_nxt;
    logic [AW-1:0] tap_cnt, tap_cnt_nxt, tap_idx;
    logic [1:0]    drain_cnt, drain_cnt_nxt;
    logic [17:0]   coef [NTAPS];
    logic          dsp_rst, s_ready, accept, capture, cw_take;
    logic          r_valid, r_ovf, ovf_acc;
    logic [47:0]   r_data;
    logic [7:0]    opmode;

    assign accept  = bus.S_VALID & s_ready;
    assign capture = (state == DRAIN) && (drain_cnt == 2'd2);
    assign cw_take = bus.CW_EN && (state == IDLE) && !accept &&
                     ({1'b0, bus.CW_ADDR} < NTAPS_W);

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state     <= IDLE;
            tap_cnt   <= '0;
            drain_cnt <= '0;
        end else begin
            state     <= state_nxt;
            tap_cnt   <= tap_cnt_nxt;
            drain_cnt <= drain_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        tap_cnt_nxt   = tap_cnt;
        drain_cnt_nxt = drain_cnt;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    if (NTAPS == 1) begin
                        state_nxt     = DRAIN;
                        drain_cnt_nxt = '0;
                    end else begin
                        state_nxt   = RUN;
                        tap_cnt_nxt = AW'(1);
                    end
                end
            end
            RUN: begin
                if (accept) begin
                    if (tap_cnt == LAST_TAP) begin
                        state_nxt     = DRAIN;
                        tap_cnt_nxt   = '0;
                        drain_cnt_nxt = '0;
                    end else begin
                        tap_cnt_nxt = tap_cnt + AW'(1);
                    end
                end
            end
            DRAIN: begin
                if (capture) begin
                    state_nxt     = IDLE;
                    drain_cnt_nxt = '0;
                end else begin
                    drain_cnt_nxt = drain_cnt + 2'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // IDLE refuses a new frame while an unconsumed result would be overwritten.
    always_comb begin
        s_ready = 1'b0;
        tap_idx = '0;
        unique case (state)
            IDLE:    s_ready = ~dsp_rst & (~r_valid | bus.R_READY);
            RUN: begin
                s_ready = 1'b1;
                tap_idx = tap_cnt;
            end
            default: s_ready = 1'b0;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            dsp_rst <= 1'b1;
            opmode  <= 8'h08;
            r_valid <= 1'b0;
            r_data  <= '0;
            r_ovf   <= 1'b0;
            ovf_acc <= 1'b0;
            for (int unsigned i = 0; i < NT; i++) coef[i] <= '0;
        end else begin
            dsp_rst <= 1'b0;
            if (accept) opmode <= (state == IDLE) ? 8'h01 : 8'h09;
            else        opmode <= 8'h08;
            if (capture) begin
                r_valid <= 1'b1;
                r_data  <= bus.DSP_P;
                r_ovf   <= ovf_acc | bus.DSP_CARRYOUT;
                ovf_acc <= 1'b0;
            end else begin
                ovf_acc <= ovf_acc | bus.DSP_CARRYOUT;
                if (bus.R_READY) r_valid <= 1'b0;
            end
            if (cw_take) coef[bus.CW_ADDR] <= bus.CW_DATA;
        end
    end

    assign bus.S_READY    = s_ready;
    assign bus.DSP_A      = accept ? coef[tap_idx] : '0;
    assign bus.DSP_B      = accept ? bus.S_DATA : '0;
    assign bus.DSP_OPMODE = opmode;
    assign bus.DSP_RST    = dsp_rst;
    assign bus.R_VALID    = r_valid;
    assign bus.R_DATA     = r_data;
    assign bus.R_OVF      = r_ovf;
    assign bus.BUSY       = (state != IDLE);
endmodule

// File: tb/tb_dsp_mac_ctrl.sv
// Bench for dsp_mac_ctrl: a slice model closes the loop, and a frame-level reference
// (sum of coef*sample per frame) is compared against every output on each falling edge.
module tb_dsp_mac_ctrl;
    localparam int NTAPS = 4;
    localparam int AW    = 2;

    logic CLK  = 1'b0;
    logic RSTN = 1'b0;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   last_acc = 0;

    dsp_mac_ctrl_if #(.AW(AW)) bus ();
    dsp_mac_ctrl #(.NTAPS(NTAPS), .AW(AW)) dut (.CLK(CLK), .RSTN(RSTN), .bus(bus));

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    // Slice: A1/B1 regs, M reg, P/CARRYOUT regs with registered OPMODE.
    logic [17:0] a_r = '0, b_r = '0;
    logic [35:0] m_r = '0;
    logic [47:0] p_r = '0;
    logic        c_r = 1'b0;
    logic [7:0]  opm_r = '0;
    logic        inject = 1'b0;

    always @(posedge CLK) begin
        if (bus.DSP_RST) begin
            a_r <= '0; b_r <= '0; m_r <= '0; p_r <= '0; c_r <= 1'b0; opm_r <= '0;
        end else begin
            a_r   <= bus.DSP_A;
            b_r   <= bus.DSP_B;
            m_r   <= {18'b0, a_r} * {18'b0, b_r};
            opm_r <= bus.DSP_OPMODE;
            case (opm_r)
                8'h01:   {c_r, p_r} <= {13'b0, m_r};
                8'h09:   {c_r, p_r} <= {1'b0, p_r} + {13'b0, m_r};
                default: c_r <= 1'b0;
            endcase
        end
    end
    assign bus.DSP_P        = p_r;
    assign bus.DSP_CARRYOUT = c_r | inject;

    // Frame-level reference state.
    logic [17:0] m_coef [NTAPS];
    int          m_taps  = 0;
    int          m_since = 0;
    logic [47:0] m_sum   = '0;
    logic [47:0] m_rdata = '0;
    logic        m_ovf   = 1'b0;
    logic        m_rvalid = 1'b0;
    logic        m_rovf  = 1'b0;
    logic        m_dsprst = 1'b1;
    logic [7:0]  m_opm   = 8'h08;

    always @(negedge CLK) begin : model_chk
        logic        exp_ready, acc, cap, ovf_now;
        logic [17:0] exp_a, exp_b;
        if (!RSTN) begin
            m_taps = 0; m_since = 0; m_sum = '0; m_ovf = 1'b0;
            m_rvalid = 1'b0; m_rdata = '0; m_rovf = 1'b0; m_dsprst = 1'b1; m_opm = 8'h08;
            foreach (m_coef[i]) m_coef[i] = '0;
        end
        if (m_taps == NTAPS)  exp_ready = 1'b0;
        else if (m_taps > 0)  exp_ready = 1'b1;
        else                  exp_ready = !m_dsprst && (!m_rvalid || bus.R_READY);
        acc   = bus.S_VALID && exp_ready;
        exp_a = acc ? m_coef[m_taps] : '0;
        exp_b = acc ? bus.S_DATA : '0;
        chk("s_ready", bus.S_READY, exp_ready);
        chk("busy", bus.BUSY, m_taps != 0);
        chk("dsp_a", bus.DSP_A, exp_a);
        chk("dsp_b", bus.DSP_B, exp_b);
        chk("opmode", bus.DSP_OPMODE, m_opm);
        chk("dsp_rst", bus.DSP_RST, m_dsprst);
        chk("r_valid", bus.R_VALID, m_rvalid);
        chk("r_data", bus.R_DATA, m_rdata);
        chk("r_ovf", bus.R_OVF, m_rovf);
        if (RSTN) begin
            cap     = (m_taps == NTAPS) && (m_since == 3);
            ovf_now = m_ovf || (inject && m_taps > 0);
            m_opm   = acc ? ((m_taps == 0) ? 8'h01 : 8'h09) : 8'h08;
            if (cap) begin
                m_rvalid = 1'b1; m_rdata = m_sum; m_rovf = ovf_now;
            end else if (bus.R_READY) begin
                m_rvalid = 1'b0;
            end
            if (m_taps == 0 && !acc && bus.CW_EN && bus.CW_ADDR < NTAPS)
                m_coef[bus.CW_ADDR] = bus.CW_DATA;
            if (cap) begin
                m_taps = 0; m_since = 0; m_sum = '0; m_ovf = 1'b0;
            end else begin
                m_ovf = ovf_now;
                if (acc) begin
                    m_sum = m_sum + 48'(m_coef[m_taps]) * 48'(bus.S_DATA);
                    m_taps++;
                    if (m_taps == NTAPS) m_since = 1;
                end else if (m_taps == NTAPS) begin
                    m_since++;
                end
            end
            m_dsprst = 1'b0;
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic cw_write(input int addr, input int data);
        bus.CW_EN   = 1'b1;
        bus.CW_ADDR = addr[AW-1:0];
        bus.CW_DATA = data[17:0];
        tick();
        bus.CW_EN = 1'b0;
    endtask

    task automatic send(input int d);
        int n;
        n = 0;
        bus.S_VALID = 1'b1;
        bus.S_DATA  = d[17:0];
        @(negedge CLK);
        while (!bus.S_READY && n < 40) begin
            @(negedge CLK);
            n++;
        end
        chk("send_accept", bus.S_READY, 1);
        last_acc = cyc;
        tick();
        bus.S_VALID = 1'b0;
        bus.S_DATA  = '0;
    endtask

    task automatic run_frame(input int s0, input int s1, input int s2, input int s3, input int gap);
        int smp [4];
        smp = '{s0, s1, s2, s3};
        for (int i = 0; i < 4; i++) begin
            send(smp[i]);
            if (i < 3) repeat (gap) tick();
        end
    endtask

    task automatic wait_result(input logic [47:0] req_d, input logic req_o, input string tag);
        int n;
        n = 0;
        @(negedge CLK);
        while (!bus.R_VALID && n < 20) begin
            @(negedge CLK);
            n++;
        end
        chk({tag, "_valid"}, bus.R_VALID, 1);
        chk({tag, "_data"}, bus.R_DATA, req_d);
        chk({tag, "_ovf"}, bus.R_OVF, req_o);
        chk({tag, "_latency"}, cyc - last_acc, 4);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.S_VALID = 1'b0; bus.S_DATA = '0; bus.CW_EN = 1'b0;
        bus.CW_ADDR = '0; bus.CW_DATA = '0; bus.R_READY = 1'b1;
        repeat (3) tick();
        RSTN = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) cw_write(i, i + 1);

        run_frame(10, 20, 30, 40, 0);
        wait_result(48'd300, 1'b0, "b2b");
        run_frame(10, 20, 30, 40, 2);
        wait_result(48'd300, 1'b0, "bubble");

        // Result held unconsumed blocks the next frame until the handshake.
        bus.R_READY = 1'b0;
        run_frame(10, 20, 30, 40, 0);
        wait_result(48'd300, 1'b0, "held");
        bus.S_VALID = 1'b1;
        bus.S_DATA  = 18'd10;
        repeat (2) begin
            @(negedge CLK);
            chk("blocked_ready", bus.S_READY, 0);
            chk("blocked_data", bus.R_DATA, 48'd300);
        end
        tick();
        bus.R_READY = 1'b1;
        @(negedge CLK);
        chk("hs_ready", bus.S_READY, 1);
        chk("hs_valid", bus.R_VALID, 1);
        tick();
        bus.S_VALID = 1'b0;
        send(20); send(30); send(40);
        wait_result(48'd300, 1'b0, "after_hs");

        send(10); send(20);
        inject = 1'b1;
        tick();
        inject = 1'b0;
        send(30); send(40);
        wait_result(48'd300, 1'b1, "ovf");
        run_frame(10, 20, 30, 40, 0);
        wait_result(48'd300, 1'b0, "clean");

        send(10);
        cw_write(1, 7);
        send(20); send(30); send(40);
        wait_result(48'd300, 1'b0, "cw_run");
        cw_write(1, 7);
        run_frame(10, 20, 30, 40, 0);
        wait_result(48'd400, 1'b0, "cw_idle");

        send(10); send(20);
        bus.S_VALID = 1'b1;
        bus.S_DATA  = 18'd30;
        RSTN = 1'b0;
        @(negedge CLK);
        chk("rst_rvalid", bus.R_VALID, 0);
        chk("rst_dsprst", bus.DSP_RST, 1);
        tick(); tick();
        RSTN = 1'b1;
        bus.S_VALID = 1'b0;
        tick(); tick();
        run_frame(5, 6, 7, 8, 1);
        wait_result(48'd0, 1'b0, "post_rst");

        for (int c = 0; c < 3000; c++) begin
            bus.S_VALID = ($urandom_range(0, 99) < 60);
            bus.S_DATA  = 18'($urandom);
            bus.R_READY = ($urandom_range(0, 99) < 70);
            bus.CW_EN   = ($urandom_range(0, 99) < 15);
            bus.CW_ADDR = AW'($urandom);
            bus.CW_DATA = 18'($urandom);
            inject      = (m_taps > 0) && ($urandom_range(0, 99) < 3);
            tick();
        end
        bus.S_VALID = 1'b0; bus.CW_EN = 1'b0; inject = 1'b0; bus.R_READY = 1'b1;
        repeat (10) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
